// File: rtl/vc_sweep_gen_if.sv
// Parameter/flag bus from the command parser and DAC staircase outputs of vc_sweep_gen.
// The parser side uses the master modport, the sweep generator uses the slave modport.
interface vc_sweep_gen_if;
  logic        i_vcReset;
  logic [11:0] i_parVc_step;
  logic [11:0] i_parVc_repeats;
  logic [11:0] i_parVc_start;
  logic [11:0] i_parVc_steps;
  logic        i_parFlag_sweepOn;
  logic        i_parFlag_sweepUp;
  logic [11:0] o_dac_code;
  logic        o_dac_strobe;
  logic        o_sweep_start;
  logic        o_busy;

  modport master (
    output i_vcReset, i_parVc_step, i_parVc_repeats, i_parVc_start, i_parVc_steps,
    output i_parFlag_sweepOn, i_parFlag_sweepUp,
    input  o_dac_code, o_dac_strobe, o_sweep_start, o_busy
  );

  modport slave (
    input  i_vcReset, i_parVc_step, i_parVc_repeats, i_parVc_start, i_parVc_steps,
    input  i_parFlag_sweepOn, i_parFlag_sweepUp,
    output o_dac_code, o_dac_strobe, o_sweep_start, o_busy
  );
endinterface

// File: rtl/vc_sweep_gen.sv
// VC sweep generator: turns the parser's start/step/steps/repeats set into a timed DAC staircase.
// Macro VC_TRIANGLE_EN selects triangle sweeps; without it every sweep restarts at start (sawtooth).
module vc_sweep_gen #(
  parameter int DWELL_CYCLES = 1000,
  parameter int DWELL_W      = 16
) (
  input logic           i_clk,
  input logic           i_rst_n,
  vc_sweep_gen_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_DWELL   = 2'd2,
    S_ADVANCE = 2'd3
  } state_t;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  // Saturating code step; bit 12 of the 13-bit result flags overflow (up) or borrow (down).
  function automatic logic [11:0] step_code(input logic [11:0] code, input logic [11:0] step,
                                            input logic up);
    logic [12:0] sum;
    logic [12:0] dif;
    sum = {1'b0, code} + {1'b0, step};
    dif = {1'b0, code} - {1'b0, step};
    if (up) begin
      step_code = sum[12] ? 12'hFFF : sum[11:0];
    end else begin
      step_code = dif[12] ? 12'h000 : dif[11:0];
    end
  endfunction

  logic vcr_meta_q, vcr_sync_q, vcr_prev_q;
  logic on_meta_q, on_sync_q, up_meta_q, up_sync_q;
  logic reload;

  state_t state_q, state_d;
  logic [11:0] sh_step_q, sh_step_d, sh_repeats_q, sh_repeats_d;
  logic [11:0] sh_start_q, sh_start_d, sh_steps_q, sh_steps_d;
  logic [11:0] idx_q, idx_d, rep_q, rep_d, code_q, code_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic dir_q, dir_d, wrap_q, wrap_d;
  logic strobe_q, strobe_d, sstart_q, sstart_d, busy_q, busy_d;
  logic go_load;
  logic [11:0] load_start, rep_last, step_last;
`ifdef VC_TRIANGLE_EN
  logic tri_dir;
`endif

  // Two-flop synchronisers for the asynchronous parser controls, plus edge history for reload.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vcr_meta_q <= 1'b0;
      vcr_sync_q <= 1'b0;
      vcr_prev_q <= 1'b0;
      on_meta_q  <= 1'b0;
      on_sync_q  <= 1'b0;
      up_meta_q  <= 1'b0;
      up_sync_q  <= 1'b0;
    end else begin
      vcr_meta_q <= bus.i_vcReset;
      vcr_sync_q <= vcr_meta_q;
      vcr_prev_q <= vcr_sync_q;
      on_meta_q  <= bus.i_parFlag_sweepOn;
      on_sync_q  <= on_meta_q;
      up_meta_q  <= bus.i_parFlag_sweepUp;
      up_sync_q  <= up_meta_q;
    end
  end

  assign reload     = vcr_sync_q & ~vcr_prev_q;
  assign load_start = reload ? bus.i_parVc_start : sh_start_q;
  assign rep_last   = (sh_repeats_q == 12'd0) ? 12'd0 : (sh_repeats_q - 12'd1);
  assign step_last  = (sh_steps_q == 12'd0) ? 12'd0 : (sh_steps_q - 12'd1);

  // Next-state and output decode; reload outranks sweepOn loss, which outranks normal sequencing.
  always_comb begin
    state_d      = state_q;
    sh_step_d    = reload ? bus.i_parVc_step : sh_step_q;
    sh_repeats_d = reload ? bus.i_parVc_repeats : sh_repeats_q;
    sh_start_d   = reload ? bus.i_parVc_start : sh_start_q;
    sh_steps_d   = reload ? bus.i_parVc_steps : sh_steps_q;
    idx_d        = idx_q;
    rep_d        = rep_q;
    dwell_d      = dwell_q;
    dir_d        = dir_q;
    wrap_d       = wrap_q;
    code_d       = code_q;
    strobe_d     = 1'b0;
    sstart_d     = 1'b0;
    busy_d       = busy_q;
    go_load      = 1'b0;
`ifdef VC_TRIANGLE_EN
    tri_dir      = dir_q;
`endif
    if (reload && (state_q != S_IDLE)) begin
      go_load = on_sync_q;
      state_d = S_IDLE;
    end else if (!on_sync_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: go_load = 1'b1;
        S_LOAD: begin
          state_d = S_DWELL;
          idx_d   = 12'd0;
          rep_d   = 12'd0;
          dwell_d = {DWELL_W{1'b0}};
          dir_d   = up_sync_q;
        end
        S_DWELL: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = {DWELL_W{1'b0}};
            if (rep_q == rep_last) begin
              rep_d   = 12'd0;
              state_d = S_ADVANCE;
`ifdef VC_TRIANGLE_EN
              // The turnaround point is shared: it ends one sweep and starts the reversed one.
              wrap_d = 1'b0;
              if (idx_q == step_last) begin
                tri_dir = ~dir_q;
                idx_d   = (step_last == 12'd0) ? 12'd0 : 12'd1;
              end else begin
                tri_dir = dir_q;
                idx_d   = idx_q + 12'd1;
              end
              dir_d    = tri_dir;
              code_d   = step_code(code_q, sh_step_q, tri_dir);
              strobe_d = 1'b1;
              sstart_d = (idx_d == step_last);
`else
              if (idx_q == step_last) begin
                wrap_d = 1'b1;
              end else begin
                wrap_d   = 1'b0;
                idx_d    = idx_q + 12'd1;
                code_d   = step_code(code_q, sh_step_q, dir_q);
                strobe_d = 1'b1;
              end
`endif
            end else begin
              rep_d = rep_q + 12'd1;
            end
          end else begin
            dwell_d = dwell_q + {{(DWELL_W-1){1'b0}}, 1'b1};
          end
        end
        S_ADVANCE: begin
          if (wrap_q) begin
            go_load = 1'b1;
          end else begin
            state_d = S_DWELL;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Point 0 is presented on entry so the strobe coincides with the LOAD state.
    if (go_load) begin
      state_d  = S_LOAD;
      code_d   = load_start;
      strobe_d = 1'b1;
      sstart_d = 1'b1;
      wrap_d   = 1'b0;
      busy_d   = 1'b1;
    end else begin
      busy_d = (state_d != S_IDLE);
    end
  end

  // State, shadow, counter and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      sh_step_q    <= 12'd4;
      sh_repeats_q <= 12'd1024;
      sh_start_q   <= 12'd0;
      sh_steps_q   <= 12'd1024;
      idx_q        <= 12'd0;
      rep_q        <= 12'd0;
      dwell_q      <= {DWELL_W{1'b0}};
      dir_q        <= 1'b1;
      wrap_q       <= 1'b0;
      code_q       <= 12'd0;
      strobe_q     <= 1'b0;
      sstart_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_step_q    <= sh_step_d;
      sh_repeats_q <= sh_repeats_d;
      sh_start_q   <= sh_start_d;
      sh_steps_q   <= sh_steps_d;
      idx_q        <= idx_d;
      rep_q        <= rep_d;
      dwell_q      <= dwell_d;
      dir_q        <= dir_d;
      wrap_q       <= wrap_d;
      code_q       <= code_d;
      strobe_q     <= strobe_d;
      sstart_q     <= sstart_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.o_dac_code    = code_q;
  assign bus.o_dac_strobe  = strobe_q;
  assign bus.o_sweep_start = sstart_q;
  assign bus.o_busy        = busy_q;
endmodule
